// File: rtl/hwpe_sel_ctrl_pkg.sv
// rtl/hwpe_sel_ctrl_pkg.sv - shared constants and types for the HWPE select controller
//
// Purpose: register indices, STATUS bit positions, select width and the
//          sequencing FSM state type used by hwpe_sel_ctrl.
// Ports:   none (package).
package hwpe_sel_ctrl_pkg;

  // Upper bound on instantiated HWPEs; sizes the select output.
  localparam int unsigned MAX_NUM_HWPES = 8;
  localparam int unsigned SEL_W         = $clog2(MAX_NUM_HWPES);

  // Register word indices (byte address bits [3:2]).
  localparam logic [1:0] REG_ENABLE = 2'd0;
  localparam logic [1:0] REG_SELECT = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  // STATUS bit positions.
  localparam int unsigned STATUS_BUSY    = 0;
  localparam int unsigned STATUS_PENDING = 1;
  localparam int unsigned STATUS_SEL_ERR = 2;
  localparam int unsigned STATUS_TIMEOUT = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_GATE  = 3'd3,
    ST_APPLY = 3'd4
  } hwpe_sel_state_e;

endpackage

// File: rtl/hwpe_sel_ctrl_if.sv
// rtl/hwpe_sel_ctrl_if.sv - peripheral config bus between cluster and HWPE select controller
//
// Purpose: bundles the request/grant and response channels of the config target port.
// Signals: req/add/wen/be/wdata/id (request, wen=1 read), gnt (grant),
//          r_rdata/r_valid/r_id (response, one cycle after grant).
// Modports: master (bus initiator), slave (hwpe_sel_ctrl side).
interface hwpe_sel_ctrl_if #(
  parameter int unsigned ID_WIDTH = 8
);

  logic                req;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         wdata;
  logic [ID_WIDTH-1:0] id;
  logic                gnt;
  logic [31:0]         r_rdata;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, wdata, id,
    input  gnt, r_rdata, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, wdata, id,
    output gnt, r_rdata, r_valid, r_id
  );

endinterface

// File: rtl/hwpe_sel_ctrl.sv
// rtl/hwpe_sel_ctrl.sv - HWPE enable/select sequencer with config register file
//
// Purpose: holds target enable/select registers written over the config bus and
//          sequences changes onto hwpe_en_o/hwpe_sel_o: drain the running HWPE,
//          gate it for SETTLE_CYCLES, apply the new select, then re-enable.
// Ports:   clk, rst_n       - clock, asynchronous active-low reset
//          cfg (slave)      - config register target port
//          busy_i           - busy flag of the currently selected HWPE
//          hwpe_en_o        - HWPE clock enable
//          hwpe_sel_o       - applied HWPE select
//          switch_evt_o     - one-cycle pulse when a select/enable update is applied
// Config:  define HWPE_SEL_CTRL_TIMEOUT_EN to add a DRAIN watchdog of TIMEOUT_CYCLES
//          that forces GATE and sets STATUS.timeout.
module hwpe_sel_ctrl
  import hwpe_sel_ctrl_pkg::*;
#(
  parameter int unsigned NUM_HWPES      = 3,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  hwpe_sel_ctrl_if.slave   cfg,
  input  logic             busy_i,
  output logic             hwpe_en_o,
  output logic [SEL_W-1:0] hwpe_sel_o,
  output logic             switch_evt_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  hwpe_sel_state_e   state_q;
  logic [CNT_W-1:0]  settle_cnt_q;
  logic              en_q;
  logic [SEL_W-1:0]  sel_q;
  logic              sel_err_q;
  logic              hwpe_en_q;
  logic [SEL_W-1:0]  hwpe_sel_q;
  logic              switch_evt_q;
  logic              r_valid_q;
  logic [ID_WIDTH-1:0] r_id_q;
  logic [31:0]       r_rdata_q;

  logic [1:0]        reg_idx;
  logic              wr_en;
  logic              sel_bad;
  logic              pending;
  logic              timeout_hit;
  logic              timeout_flag;
  logic [31:0]       rdata_mux;

  assign reg_idx = cfg.add[3:2];
  assign wr_en   = cfg.req & ~cfg.wen & cfg.be[0];
  assign sel_bad = (cfg.wdata >= 32'(NUM_HWPES));
  assign pending = (state_q == ST_DRAIN) || (state_q == ST_GATE) || (state_q == ST_APPLY);

  logic unused_cfg;
  assign unused_cfg = ^{cfg.add[31:4], cfg.add[1:0], cfg.be[3:1]};

  // No back-pressure: every request is granted in the same cycle.
  assign cfg.gnt     = cfg.req;
  assign cfg.r_valid = r_valid_q;
  assign cfg.r_id    = r_id_q;
  assign cfg.r_rdata = r_rdata_q;

  assign hwpe_en_o    = hwpe_en_q;
  assign hwpe_sel_o   = hwpe_sel_q;
  assign switch_evt_o = switch_evt_q;

  always_comb begin
    rdata_mux = '0;
    case (reg_idx)
      REG_ENABLE: rdata_mux[0] = en_q;
      REG_SELECT: rdata_mux[SEL_W-1:0] = sel_q;
      REG_STATUS: begin
        rdata_mux[STATUS_BUSY]    = busy_i;
        rdata_mux[STATUS_PENDING] = pending;
        rdata_mux[STATUS_SEL_ERR] = sel_err_q;
        rdata_mux[STATUS_TIMEOUT] = timeout_flag;
      end
      default: rdata_mux = '0;
    endcase
  end

  // Target registers. Out-of-range selects are dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else if (wr_en) begin
      case (reg_idx)
        REG_ENABLE: en_q <= cfg.wdata[0];
        REG_SELECT: begin
          if (sel_bad) sel_err_q <= 1'b1;
          else         sel_q     <= cfg.wdata[SEL_W-1:0];
        end
        REG_STATUS: if (cfg.wdata[STATUS_SEL_ERR]) sel_err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Response channel: one cycle after the grant, writes return zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_rdata_q <= '0;
    end else begin
      r_valid_q <= cfg.req;
      if (cfg.req) begin
        r_id_q    <= cfg.id;
        r_rdata_q <= cfg.wen ? rdata_mux : 32'd0;
      end
    end
  end

`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              timeout_q;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in DRAIN with the HWPE still busy.
  assign timeout_hit  = (state_q == ST_DRAIN) && busy_i &&
                        (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Held at zero outside DRAIN so every DRAIN visit starts from zero.
      if (state_q == ST_DRAIN) wdog_q <= wdog_q + WDOG_W'(1);
      else                     wdog_q <= '0;
      if (timeout_hit)
        timeout_q <= 1'b1;
      else if (wr_en && (reg_idx == REG_STATUS) && cfg.wdata[STATUS_TIMEOUT])
        timeout_q <= 1'b0;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Sequencer. Outputs are registered; writes landing during DRAIN/GATE are
  // simply picked up when APPLY samples the targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      hwpe_en_q    <= 1'b0;
      hwpe_sel_q   <= '0;
      switch_evt_q <= 1'b0;
    end else begin
      switch_evt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // HWPE is already gated, so a new select can be applied directly.
          if (sel_q != hwpe_sel_q) begin
            hwpe_sel_q   <= sel_q;
            switch_evt_q <= 1'b1;
          end
          if (en_q) begin
            state_q      <= ST_GATE;
            settle_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if ((sel_q != hwpe_sel_q) || !en_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!busy_i || timeout_hit) begin
            state_q      <= ST_GATE;
            hwpe_en_q    <= 1'b0;
            settle_cnt_q <= '0;
          end
        end
        ST_GATE: begin
          if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_q <= ST_APPLY;
          else settle_cnt_q <= settle_cnt_q + CNT_W'(1);
        end
        ST_APPLY: begin
          hwpe_sel_q   <= sel_q;
          switch_evt_q <= 1'b1;
          hwpe_en_q    <= en_q;
          state_q      <= en_q ? ST_RUN : ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          hwpe_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_sel_ctrl.sv
// tb/tb_hwpe_sel_ctrl.sv - self-checking bench for hwpe_sel_ctrl
//
// Purpose: directed sequencing scenarios plus a randomized register phase
//          checked against a transaction-level model of the targets.
// Ports:   none (top-level bench). Honours HWPE_SEL_CTRL_TIMEOUT_EN.
module tb_hwpe_sel_ctrl;

  localparam int unsigned NUM     = 3;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic       busy_i;
  logic       hwpe_en_o;
  logic [2:0] hwpe_sel_o;
  logic       switch_evt_o;

  int checks   = 0;
  int failures = 0;
  int evt_cnt  = 0;
  int sel_viol = 0;
  logic       prev_en;
  logic [2:0] prev_sel;

  hwpe_sel_ctrl_if #(.ID_WIDTH(8)) cfg ();

  hwpe_sel_ctrl #(
    .NUM_HWPES(NUM), .ID_WIDTH(8), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg), .busy_i(busy_i),
    .hwpe_en_o(hwpe_en_o), .hwpe_sel_o(hwpe_sel_o), .switch_evt_o(switch_evt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter and safety monitor: the select must never move while enabled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (switch_evt_o) evt_cnt++;
      if (prev_en && (hwpe_sel_o != prev_sel)) sel_viol++;
    end
    prev_en  = hwpe_en_o;
    prev_sel = hwpe_sel_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic wen, input logic [1:0] idx, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata);
    logic [7:0] id;
    id = 8'($urandom);
    cfg.req   = 1'b1;
    cfg.wen   = wen;
    cfg.add   = {28'($urandom), idx, 2'b00};
    cfg.be    = be;
    cfg.wdata = wdata;
    cfg.id    = id;
    #1;
    chk("gnt", 32'(cfg.gnt), 32'd1);
    @(posedge clk);
    #1;
    cfg.req = 1'b0;
    chk("r_valid", 32'(cfg.r_valid), 32'd1);
    chk("r_id", 32'(cfg.r_id), 32'(id));
    if (!wen) chk("wr_rdata_zero", cfg.r_rdata, 32'd0);
    rdata = cfg.r_rdata;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] wdata);
    logic [31:0] d;
    bus(1'b0, idx, wdata, 4'hF, d);
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] d);
    bus(1'b1, idx, 32'h0, 4'hF, d);
  endtask

  initial begin
    logic [31:0] d;
    int          e0;
    logic        en_m;
    logic [2:0]  sel_m;
    logic        err_m;
    logic [1:0]  idx;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wd;

    rst_n = 1'b0; busy_i = 1'b0;
    cfg.req = 1'b0; cfg.wen = 1'b0; cfg.add = '0; cfg.be = '0; cfg.wdata = '0; cfg.id = '0;
    en_m = 1'b0; sel_m = 3'd0; err_m = 1'b0;
    repeat (3) tick();
    chk("rst_en", 32'(hwpe_en_o), 32'd0);
    chk("rst_sel", 32'(hwpe_sel_o), 32'd0);
    chk("rst_evt", 32'(switch_evt_o), 32'd0);
    chk("rst_rvalid", 32'(cfg.r_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset state readback.
    rd(REG_IDX(2), d);
    chk("rst_status", d, 32'd0);
    tick();
    chk("rvalid_drop", 32'(cfg.r_valid), 32'd0);

    // IDLE: select applied directly with one pulse, then enable via GATE/APPLY.
    e0 = evt_cnt;
    wr(REG_IDX(1), 32'd1);
    tick();
    chk("idle_sel", 32'(hwpe_sel_o), 32'd1);
    chk("idle_evt", 32'(switch_evt_o), 32'd1);
    chk("idle_en", 32'(hwpe_en_o), 32'd0);
    tick();
    chk("idle_evt_cnt", 32'(evt_cnt - e0), 32'd1);
    wr(REG_IDX(0), 32'd1);
    for (int k = 1; k <= SETTLE + 2; k++) begin
      tick();
      chk($sformatf("en_rise_k%0d", k), 32'(hwpe_en_o), 32'(k == SETTLE + 2));
    end
    chk("en_rise_evt", 32'(switch_evt_o), 32'd1);
    chk("en_rise_sel", 32'(hwpe_sel_o), 32'd1);
    en_m = 1'b1; sel_m = 3'd1;

    // RUN: reselect while busy; must hold until busy drops.
    busy_i = 1'b1;
    wr(REG_IDX(1), 32'd2);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("drain_en_hold", 32'(hwpe_en_o), 32'd1);
      chk("drain_sel_hold", 32'(hwpe_sel_o), 32'd1);
    end
    rd(REG_IDX(2), d);
    chk("drain_status", d, 32'h3);
    busy_i = 1'b0;
    // Gate window plus the apply cycle, then enabled on the new select.
    for (int k = 1; k <= SETTLE + 2; k++) begin
      tick();
      chk($sformatf("switch_en_k%0d", k), 32'(hwpe_en_o), 32'(k == SETTLE + 2));
      chk($sformatf("switch_sel_k%0d", k), 32'(hwpe_sel_o), (k == SETTLE + 2) ? 32'd2 : 32'd1);
    end
    sel_m = 3'd2;

    // Out-of-range select, W1C, masked write, unmapped word.
    wr(REG_IDX(1), 32'd5);
    rd(REG_IDX(1), d);
    chk("bad_sel_dropped", d, 32'd2);
    rd(REG_IDX(2), d);
    chk("sel_err_set", d, 32'h4);
    wr(REG_IDX(2), 32'h4);
    rd(REG_IDX(2), d);
    chk("sel_err_clr", d, 32'h0);
    bus(1'b0, REG_IDX(0), 32'd0, 4'hE, d);
    rd(REG_IDX(0), d);
    chk("be0_masked", d, 32'd1);
    wr(REG_IDX(3), 32'hFFFF_FFFF);
    rd(REG_IDX(3), d);
    chk("word3_zero", d, 32'd0);
    chk("bad_sel_out", 32'(hwpe_sel_o), 32'd2);

    // Writes during GATE: last one wins, one pulse total.
    e0 = evt_cnt;
    wr(REG_IDX(1), 32'd1);
    tick(); tick();
    wr(REG_IDX(1), 32'd0);
    wr(REG_IDX(1), 32'd2);
    repeat (8) tick();
    chk("gate_last_wins", 32'(hwpe_sel_o), 32'd2);
    chk("gate_en", 32'(hwpe_en_o), 32'd1);
    chk("gate_one_pulse", 32'(evt_cnt - e0), 32'd1);

    // DRAIN with busy stuck high.
    busy_i = 1'b1;
    wr(REG_IDX(1), 32'd1);
`ifdef HWPE_SEL_CTRL_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      tick();
      chk($sformatf("wdog_en_k%0d", k), 32'(hwpe_en_o), 32'(k <= TIMEOUT));
    end
    rd(REG_IDX(2), d);
    chk("timeout_flag", 32'(d[3]), 32'd1);
    wr(REG_IDX(2), 32'h8);
    rd(REG_IDX(2), d);
    chk("timeout_clr", 32'(d[3]), 32'd0);
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("drain_forever", 32'(hwpe_en_o), 32'd1);
    end
    rd(REG_IDX(2), d);
    chk("no_timeout_bit", 32'(d[3]), 32'd0);
`endif
    busy_i = 1'b0;
    repeat (10) tick();
    chk("stuck_sel", 32'(hwpe_sel_o), 32'd1);
    chk("stuck_en", 32'(hwpe_en_o), 32'd1);
    sel_m = 3'd1;

    // Randomized register traffic against the target model.
    for (int i = 0; i < 60; i++) begin
      busy_i = 1'($urandom);
      idx    = 2'($urandom);
      wen    = 1'($urandom);
      be     = 4'($urandom);
      wd     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      bus(wen, idx, wd, be, d);
      if (wen) begin
        case (idx)
          2'd0: chk("rnd_enable", d, 32'(en_m));
          2'd1: chk("rnd_select", d, 32'(sel_m));
          2'd2: chk("rnd_status", d & 32'hFFFF_FFF4, 32'(err_m) << 2);
          default: chk("rnd_word3", d, 32'd0);
        endcase
      end else if (be[0]) begin
        case (idx)
          2'd0: en_m = wd[0];
          2'd1: if (wd >= 32'(NUM)) err_m = 1'b1; else sel_m = wd[2:0];
          2'd2: if (wd[2]) err_m = 1'b0;
          default: ;
        endcase
      end
    end
    busy_i = 1'b0;
    repeat (20) tick();
    chk("rnd_conv_en", 32'(hwpe_en_o), 32'(en_m));
    chk("rnd_conv_sel", 32'(hwpe_sel_o), 32'(sel_m));
    rd(REG_IDX(2), d);
    chk("rnd_conv_status", d & 32'h7, 32'(err_m) << 2);
    chk("sel_stable_while_en", 32'(sel_viol), 32'd0);

    // Reset in the middle of a drain.
    wr(REG_IDX(0), 32'd1);
    repeat (10) tick();
    busy_i = 1'b1;
    wr(REG_IDX(1), (sel_m == 3'd0) ? 32'd1 : 32'd0);
    repeat (3) tick();
    chk("pre_rst_en", 32'(hwpe_en_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(hwpe_en_o), 32'd0);
    chk("mid_rst_sel", 32'(hwpe_sel_o), 32'd0);
    chk("mid_rst_evt", 32'(switch_evt_o), 32'd0);
    chk("mid_rst_rvalid", 32'(cfg.r_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    busy_i = 1'b0;
    tick();
    rd(REG_IDX(0), d);
    chk("post_rst_enable", d, 32'd0);
    rd(REG_IDX(1), d);
    chk("post_rst_select", d, 32'd0);
    rd(REG_IDX(2), d);
    chk("post_rst_status", d, 32'd0);
    repeat (5) tick();
    chk("post_rst_disabled", 32'(hwpe_en_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [1:0] REG_IDX(input int i);
    return 2'(i);
  endfunction

endmodule
